// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V 5-stage pipeline: datapath width,
// ALU op codes, forwarding selects and result-source codes.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } res_src_e;

  // The unused select code 11 falls back to the register-file operand.
  function automatic logic [XLEN-1:0] fwd_mux(
    input logic [1:0]      sel,
    input logic [XLEN-1:0] rf_val,
    input logic [XLEN-1:0] wb_val,
    input logic [XLEN-1:0] mem_val
  );
    logic [XLEN-1:0] val;
    case (sel)
      FWD_WB:  val = wb_val;
      FWD_MEM: val = mem_val;
      default: val = rf_val;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU for the execute stage; arithmetic wraps mod 2^32 and
// shift amounts use only the low five bits of b.
import riscv_pkg::*;

module alu #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   ALUControl,
  output logic [W-1:0] result,
  output logic         zero
);

  always_comb begin
    result = '0;
    case (alu_op_e'(ALUControl))
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLL: result = a << b[4:0];
      ALU_SRL: result = a >> b[4:0];
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump redirect and the
// EX/MEM pipeline register feeding the memory-access stage.
import riscv_pkg::*;

module execute_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            JumpE,
  input  logic            BranchE,
  input  logic            ALUSrcE,
  input  logic [1:0]      ResultSrcE,
  input  logic [2:0]      ALUControlE,
  input  logic [4:0]      RdE,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [4:0]      RdM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M
);

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b_fwd;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;

  // MEM-forwarding reads our own EX/MEM register, i.e. the previous instruction.
  assign src_a     = fwd_mux(ForwardAE, RD1_E, ResultW, ALUResultM);
  assign src_b_fwd = fwd_mux(ForwardBE, RD2_E, ResultW, ALUResultM);
  assign src_b     = ALUSrcE ? ImmExtE : src_b_fwd;

  alu #(.W(XLEN)) u_alu (
    .a          (src_a),
    .b          (src_b),
    .ALUControl (ALUControlE),
    .result     (alu_result),
    .zero       (alu_zero)
  );

  // Only beq exists, so a taken branch is simply a zero SUB result.
  assign PCTargetE = PCE + ImmExtE;
  assign PCSrcE    = JumpE | (BranchE & alu_zero);

  // Store data is the forwarded rs2 value, never the immediate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 2'b00;
      RdM        <= 5'd0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
    end else begin
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      RdM        <= RdE;
      ALUResultM <= alu_result;
      WriteDataM <= src_b_fwd;
      PCPlus4M   <= PCPlus4E;
    end
  end

endmodule
